// File: rtl/fpu_sequencer.sv
// FPU front-end sequencer: accepts one op, times it with a per-class
// latency counter, returns the result and accumulates sticky fflags.
module fpu_sequencer #(
  parameter int FLEN     = 32,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      req_op,
  input  logic [FLEN-1:0] req_rs1,
  input  logic [FLEN-1:0] req_rs2,
  input  logic [2:0]      req_rm,
  input  logic [2:0]      frm,
  output logic [5:0]      fpu_operation,
  output logic [FLEN-1:0] fpu_rs1,
  output logic [FLEN-1:0] fpu_rs2,
  output logic [2:0]      fpu_rm,
  output logic            fpu_start,
  input  logic [FLEN-1:0] fpu_result,
  input  logic [4:0]      fpu_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [FLEN-1:0] resp_result,
  output logic [4:0]      resp_flags,
  output logic [4:0]      fflags,
  input  logic            fflags_clr,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic            req_ready_q;
  logic [5:0]      op_q;
  logic [FLEN-1:0] rs1_q;
  logic [FLEN-1:0] rs2_q;
  logic [2:0]      rm_q;
  logic            start_q;
  logic [7:0]      cnt_q;
  logic            resp_valid_q;
  logic [FLEN-1:0] resp_result_q;
  logic [4:0]      resp_flags_q;
  logic [4:0]      fflags_q;
  logic [4:0]      fflags_d;
  logic            busy_q;

  logic [2:0]      rm_res;
  logic            illegal;
  logic [7:0]      lat_sel;
  logic            resp_hs;

  // Resolve the dynamic rounding mode and classify the request
  always_comb begin
    rm_res  = (req_rm == 3'd7) ? frm : req_rm;
    illegal = (req_op > 6'd4) || (rm_res >= 3'd5);
  end

  // Latency for the op class currently held on the FPU bus
  always_comb begin
    lat_sel = 8'd1;
    case (op_q)
      6'd0:    lat_sel = 8'(LAT_ADD);
      6'd1:    lat_sel = 8'(LAT_MUL);
      6'd2:    lat_sel = 8'(LAT_DIV);
      6'd3:    lat_sel = 8'(LAT_SQRT);
      6'd4:    lat_sel = 8'(LAT_CVT);
      default: lat_sel = 8'd1;
    endcase
  end

  // Sticky flags: clear first, then OR in a completing response
  always_comb begin
    resp_hs  = (state_q == RESP) && resp_ready;
    fflags_d = fflags_clr ? 5'b0 : fflags_q;
    if (resp_hs) fflags_d = fflags_d | resp_flags_q;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      op_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rm_q          <= '0;
      start_q       <= 1'b0;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      fflags_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      fflags_q <= fflags_d;
      start_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            rs1_q       <= req_rs1;
            rs2_q       <= req_rs2;
            rm_q        <= rm_res;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (illegal) begin
              state_q       <= RESP;
              resp_valid_q  <= 1'b1;
              resp_result_q <= FLEN'(32'h7FC0_0000);
              resp_flags_q  <= 5'b10000;
            end else begin
              state_q <= ISSUE;
              start_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= lat_sel;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            resp_result_q <= fpu_result;
            resp_flags_q  <= fpu_flags;
            resp_valid_q  <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign fpu_operation = op_q;
  assign fpu_rs1       = rs1_q;
  assign fpu_rs2       = rs2_q;
  assign fpu_rm        = rm_q;
  assign fpu_start     = start_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = resp_result_q;
  assign resp_flags    = resp_flags_q;
  assign fflags        = fflags_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: latency per op class, dynamic rm,
// illegal ops, backpressure, mid-op reset and sticky flag clearing.
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [2:0]  req_rm;
  logic [2:0]  frm;
  logic [5:0]  fpu_operation;
  logic [31:0] fpu_rs1;
  logic [31:0] fpu_rs2;
  logic [2:0]  fpu_rm;
  logic        fpu_start;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          nstart;
  int          kstart;
  int          kresp;
  logic [2:0]  rm_seen;

  fpu_sequencer dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_rs1(req_rs1),
    .req_rs2(req_rs2),
    .req_rm(req_rm),
    .frm(frm),
    .fpu_operation(fpu_operation),
    .fpu_rs1(fpu_rs1),
    .fpu_rs2(fpu_rs2),
    .fpu_rm(fpu_rm),
    .fpu_start(fpu_start),
    .fpu_result(fpu_result),
    .fpu_flags(fpu_flags),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_result(resp_result),
    .resp_flags(resp_flags),
    .fflags(fflags),
    .fflags_clr(fflags_clr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Present one request in cycle T, then act as the FPU: the correct
  // result/flags appear only in cycle T+1+lat, garbage otherwise.
  // Returns start-pulse count, first start cycle and response cycle.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] rm,
                       input logic [2:0] f, input logic [31:0] res,
                       input logic [4:0] flg, input int lat,
                       output int ns, output int ks, output int kr,
                       output logic [2:0] rms);
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_rm    = rm;
    frm       = f;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1   = 32'hDEAD_BEEF;
    req_rs2   = 32'hDEAD_BEEF;
    req_op    = 6'h3F;
    ns  = 0;
    ks  = -1;
    kr  = -1;
    rms = fpu_rm;
    for (int k = 1; k <= 40; k++) begin
      if (fpu_start) begin
        ns++;
        if (ks < 0) ks = k;
      end
      if (resp_valid) begin
        kr = k;
        break;
      end
      fpu_result = (k == lat + 1) ? res : 32'hBAD0_BAD0;
      fpu_flags  = (k == lat + 1) ? flg : 5'b11111;
      @(negedge clk);
    end
  endtask

  task automatic handshake(input logic clr);
    resp_ready = 1'b1;
    fflags_clr = clr;
    @(negedge clk);
    resp_ready = 1'b0;
    fflags_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid);
    end
    checks++;
    if (fflags !== 5'b0) begin
      errors++; $display("FAIL rst_fflags got %b exp 00000", fflags);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b exp 0", busy);
    end
    checks++;
    if (fpu_start !== 1'b0) begin
      errors++; $display("FAIL rst_fpu_start got %b exp 0", fpu_start);
    end
  endtask

  task automatic test_add();
    do_op(6'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 3'd0,
          32'h4040_0000, 5'b0, 3, nstart, kstart, kresp, rm_seen);
    checks++;
    if (nstart !== 1 || kstart !== 1) begin
      errors++;
      $display("FAIL add_start count %0d at %0d exp 1 at 1", nstart, kstart);
    end
    checks++;
    if (kresp !== 5) begin
      errors++; $display("FAIL add_latency got %0d exp 5", kresp);
    end
    checks++;
    if (resp_result !== 32'h4040_0000 || resp_flags !== 5'b0) begin
      errors++;
      $display("FAIL add_result got %h/%b exp 40400000/00000",
               resp_result, resp_flags);
    end
    checks++;
    if (fpu_operation !== 6'd0 || fpu_rs1 !== 32'h3F80_0000 ||
        fpu_rs2 !== 32'h4000_0000) begin
      errors++;
      $display("FAIL add_bus_hold got %0d %h %h exp 0 3f800000 40000000",
               fpu_operation, fpu_rs1, fpu_rs2);
    end
    handshake(1'b0);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_return_idle got busy=%b rdy=%b rv=%b exp 0 1 0",
               busy, req_ready, resp_valid);
    end
  endtask

  task automatic test_dynamic_rm();
    do_op(6'd2, 32'h4120_0000, 32'h0, 3'd7, 3'd3,
          32'h7F80_0000, 5'b01000, 16, nstart, kstart, kresp, rm_seen);
    checks++;
    if (rm_seen !== 3'd3) begin
      errors++; $display("FAIL div_rm got %0d exp 3", rm_seen);
    end
    checks++;
    if (kresp !== 18) begin
      errors++; $display("FAIL div_latency got %0d exp 18", kresp);
    end
    checks++;
    if (resp_flags !== 5'b01000 || resp_result !== 32'h7F80_0000) begin
      errors++;
      $display("FAIL div_result got %h/%b exp 7f800000/01000",
               resp_result, resp_flags);
    end
    handshake(1'b0);
    checks++;
    if (fflags !== 5'b01000) begin
      errors++; $display("FAIL div_fflags got %b exp 01000", fflags);
    end
    do_op(6'd1, 32'h4000_0000, 32'h4040_0000, 3'd1, 3'd3,
          32'h40C0_0000, 5'b00001, 4, nstart, kstart, kresp, rm_seen);
    checks++;
    if (kresp !== 6 || rm_seen !== 3'd1) begin
      errors++;
      $display("FAIL mul_latency_rm got %0d/%0d exp 6/1", kresp, rm_seen);
    end
    handshake(1'b0);
    checks++;
    if (fflags !== 5'b01001) begin
      errors++; $display("FAIL mul_fflags got %b exp 01001", fflags);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [3] = '{6'd9, 6'd0, 6'd0};
    logic [2:0] rms [3] = '{3'd0, 3'd5, 3'd7};
    logic [2:0] frs [3] = '{3'd0, 3'd0, 3'd6};
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 32'h1, 32'h2, rms[i], frs[i],
            32'h0, 5'b0, 0, nstart, kstart, kresp, rm_seen);
      checks++;
      if (nstart !== 0) begin
        errors++; $display("FAIL illegal%0d_start got %0d exp 0", i, nstart);
      end
      checks++;
      if (kresp !== 1) begin
        errors++; $display("FAIL illegal%0d_latency got %0d exp 1", i, kresp);
      end
      checks++;
      if (resp_result !== 32'h7FC0_0000 || resp_flags !== 5'b10000) begin
        errors++;
        $display("FAIL illegal%0d_result got %h/%b exp 7fc00000/10000",
                 i, resp_result, resp_flags);
      end
      handshake(1'b0);
    end
    checks++;
    if (fflags !== 5'b11001) begin
      errors++; $display("FAIL illegal_fflags got %b exp 11001", fflags);
    end
  endtask

  task automatic test_backpressure();
    do_op(6'd4, 32'h4049_0FDB, 32'h0, 3'd2, 3'd0,
          32'h1234_5678, 5'b00010, 2, nstart, kstart, kresp, rm_seen);
    checks++;
    if (kresp !== 4) begin
      errors++; $display("FAIL cvt_latency got %0d exp 4", kresp);
    end
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_op    = 6'd0;
      req_rs1   = 32'h5555_5555;
      req_rm    = 3'd0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
          resp_result !== 32'h1234_5678 || resp_flags !== 5'b00010) begin
        errors++;
        $display("FAIL bp_hold%0d got rv=%b rdy=%b %h/%b exp 1 0 12345678/00010",
                 i, resp_valid, req_ready, resp_result, resp_flags);
      end
    end
    req_valid = 1'b0;
    checks++;
    if (fpu_operation !== 6'd4 || fpu_rs1 !== 32'h4049_0FDB) begin
      errors++;
      $display("FAIL bp_not_latched got %0d/%h exp 4/40490fdb",
               fpu_operation, fpu_rs1);
    end
    handshake(1'b0);
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got busy=%b rdy=%b rv=%b exp 0 1 0",
               busy, req_ready, resp_valid);
    end
    checks++;
    if (fflags !== 5'b11011) begin
      errors++; $display("FAIL bp_fflags got %b exp 11011", fflags);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    req_op    = 6'd3;
    req_rs1   = 32'h4080_0000;
    req_rm    = 3'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sqrt_in_wait got busy=%b rv=%b exp 1 0", busy, resp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || fpu_start !== 1'b0 || resp_valid !== 1'b0 ||
        fflags !== 5'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst got busy=%b st=%b rv=%b ff=%b rdy=%b exp 0 0 0 0 1",
               busy, fpu_start, resp_valid, fflags, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      fpu_result = 32'h4000_0000 + 32'(i);
      fpu_flags  = 5'(i);
      @(negedge clk);
      if (resp_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_resp got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic test_fflags_clr();
    do_op(6'd0, 32'h1, 32'h2, 3'd0, 3'd0,
          32'h3, 5'b10001, 3, nstart, kstart, kresp, rm_seen);
    handshake(1'b0);
    checks++;
    if (fflags !== 5'b10001) begin
      errors++; $display("FAIL clr_prior got %b exp 10001", fflags);
    end
    do_op(6'd1, 32'h1, 32'h2, 3'd0, 3'd0,
          32'h4, 5'b00100, 4, nstart, kstart, kresp, rm_seen);
    checks++;
    if (resp_flags !== 5'b00100) begin
      errors++; $display("FAIL clr_resp_flags got %b exp 00100", resp_flags);
    end
    handshake(1'b1);
    checks++;
    if (fflags !== 5'b00100) begin
      errors++; $display("FAIL clr_with_hs got %b exp 00100", fflags);
    end
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    checks++;
    if (fflags !== 5'b0) begin
      errors++; $display("FAIL clr_idle got %b exp 00000", fflags);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_rm     = '0;
    frm        = '0;
    fpu_result = '0;
    fpu_flags  = '0;
    resp_ready = 1'b0;
    fflags_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_dynamic_rm();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_fflags_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
